inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
- Boot-time program loader: the writing end of the instruction memory, which the core only ever reads.
- Accepts a byte stream (valid/ready) carrying a 16-bit word count followed by little-endian 32-bit instruction words.
- Writes each assembled word to consecutive instruction-memory addresses starting at 0.
- Holds the core in reset (core_rst) until the whole image is loaded.

Parameters:
INST_WIDTH, 32, instruction word width; fixed at 4 bytes, other values unsupported.
INST_MEMORY_ADDRESS_WIDTH, 10, instruction memory word-address width; depth = 2^INST_MEMORY_ADDRESS_WIDTH words.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse: begin a load (honoured in IDLE, DONE, ERROR only)
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader can accept a byte this cycle
mem_w_en  output  1  instruction-memory write strobe, one cycle per word
mem_w_addr  output  INST_MEMORY_ADDRESS_WIDTH  word address of the write
mem_w_data  output  INST_WIDTH  word being written
core_rst  output  1  reset to the core, high whenever no valid image is resident
busy  output  1  load in progress
done  output  1  load completed successfully (level, held)
error  output  1  header rejected (level, held)

Behaviour:
- Reset, sampled on clk when rst=1:
  - state=IDLE, core_rst=1.
  - rx_ready, mem_w_en, busy, done, error = 0; mem_w_addr=0, mem_w_data=0.
  - Internal byte counter, word counter and count register all 0.
- rst during any state aborts the load immediately with the same result.
- A byte transfer occurs only on a cycle with rx_valid=1 and rx_ready=1. rx_data is ignored at all other times.
- rx_ready is a registered function of state: 1 in HDR0, HDR1 and DATA; 0 elsewhere.
- States:
  - IDLE: core_rst=1. On start: go to HDR0; busy=1; clear done, error, word counter and mem_w_addr.
  - HDR0: on transfer, count[7:0]=rx_data; go to HDR1.
  - HDR1: on transfer, count[15:8]=rx_data. Then:
    - If the full count is 0 or exceeds 2^INST_MEMORY_ADDRESS_WIDTH: go to ERROR.
    - Otherwise go to DATA with byte index=0.
  - DATA: on each transfer, the byte is placed at lane [8*i+7:8*i] of the word, i = byte index 0..3 (first byte is LSB). After lane 3 is accepted, go to WRITE.
  - WRITE: lasts exactly one cycle, rx_ready=0, mem_w_en=1, mem_w_addr=current word index, mem_w_data=assembled word. On the next edge:
    - increment the word index;
    - if the index now equals count, go to DONE;
    - otherwise return to DATA with byte index=0.
  - DONE: busy=0, done=1, core_rst=0 (core released the cycle after the last write). start returns to HDR0 with core_rst=1 asserted the next cycle.
  - ERROR: busy=0, error=1, core_rst=1, rx_ready=0. Left only by start (to HDR0) or rst.
- Latency: the write strobe appears exactly 1 cycle after the edge on which the 4th byte of a word is accepted.
- Minimum 5 cycles per word; rx_valid gaps stall assembly indefinitely without a timeout.
- mem_w_addr and mem_w_data hold their last values when mem_w_en=0.
- start while busy=1 is ignored.
- start and rx_valid in the same cycle in IDLE: that cycle's byte is not consumed, because rx_ready=0 in IDLE.
- count = 2^INST_MEMORY_ADDRESS_WIDTH is legal and fills the memory. The address counter wraps to 0 after the final write and is never used again before DONE.

Test Plan:
- Reset behaviour: rst high 2 cycles -> core_rst=1; busy, done, error, rx_ready, mem_w_en all 0; mem_w_addr=0.
- Basic load: start, then bytes 02 00 | 13 05 10 00 | 93 05 20 00 with rx_valid always 1 -> two mem_w_en pulses: addr 0 data 0x00100513, then addr 1 data 0x00200593. DONE the cycle after the second write: done=1, core_rst=0.
- Backpressure and gaps: same image with rx_valid toggling 1/0 each cycle -> identical writes and data. No byte lost or duplicated; rx_ready=0 during each WRITE cycle.
- Header errors:
  - count 00 00 -> error=1, core_rst=1, no mem_w_en.
  - With AW=10, count 01 04 (0x401) -> error=1.
  - With AW=10, count 00 04 (1024 words) -> accepted, 1024 writes, last addr 0x3FF.
- Abort and restart:
  - rst asserted after 2 of 4 data bytes -> IDLE, partial word never written.
  - start then a fresh 1-word image 01 00 EF BE AD DE -> single write, addr 0, data 0xDEADBEEF.
- Reload from DONE: after a completed load, pulse start -> core_rst=1 next cycle, done cleared; new image overwrites from addr 0.

Source files
------------

// File: rtl/inst_loader.sv
// inst_loader: boot-time loader that turns a counted little-endian byte stream into
// instruction-memory writes and holds the core in reset until a full image is resident.
module inst_loader #(
    parameter int INST_WIDTH = 32,
    parameter int INST_MEMORY_ADDRESS_WIDTH = 10
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [7:0]                           rx_data,
    input  logic                                 rx_valid,
    output logic                                 rx_ready,
    output logic                                 mem_w_en,
    output logic [INST_MEMORY_ADDRESS_WIDTH-1:0] mem_w_addr,
    output logic [INST_WIDTH-1:0]                mem_w_data,
    output logic                                 core_rst,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 error
);
    localparam int AW = INST_MEMORY_ADDRESS_WIDTH;

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERROR} state_t;

    state_t        state, next_state;
    logic [7:0]    cnt_lo;
    logic [AW:0]   count, word_cnt;
    logic [1:0]    byte_idx;
    logic [23:0]   word_buf;
    logic [15:0]   hdr_count;
    logic          xfer, hdr_bad, last_word, start_ok;
    logic          rx_ready_d, busy_d, core_rst_d, mem_w_en_d, done_d, error_d;

    assign xfer      = rx_valid && rx_ready;
    assign hdr_count = {rx_data, cnt_lo};
    assign hdr_bad   = hdr_count == 16'd0 || hdr_count > 16'(1 << AW);
    assign last_word = word_cnt + 1'b1 == count;
    assign start_ok  = start && (state == IDLE || state == DONE || state == ERROR);

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERROR: if (start) next_state = HDR0;
            HDR0:              if (xfer) next_state = HDR1;
            HDR1:              if (xfer) next_state = hdr_bad ? ERROR : DATA;
            DATA:              if (xfer && byte_idx == 2'd3) next_state = WRITE;
            WRITE:             next_state = last_word ? DONE : DATA;
            default:           next_state = IDLE;
        endcase
    end

    // Status outputs are registered from next_state so they track the state register exactly.
    always_comb begin
        rx_ready_d = next_state == HDR0 || next_state == HDR1 || next_state == DATA;
        busy_d     = rx_ready_d || next_state == WRITE;
        mem_w_en_d = next_state == WRITE;
        done_d     = next_state == DONE;
        error_d    = next_state == ERROR;
        core_rst_d = next_state != DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rx_ready   <= 1'b0;
            busy       <= 1'b0;
            mem_w_en   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            core_rst   <= 1'b1;
            mem_w_addr <= '0;
            mem_w_data <= '0;
            cnt_lo     <= '0;
            count      <= '0;
            word_cnt   <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
        end else begin
            state    <= next_state;
            rx_ready <= rx_ready_d;
            busy     <= busy_d;
            mem_w_en <= mem_w_en_d;
            done     <= done_d;
            error    <= error_d;
            core_rst <= core_rst_d;
            if (start_ok) begin
                word_cnt   <= '0;
                mem_w_addr <= '0;
                byte_idx   <= '0;
            end
            if (state == HDR0 && xfer)
                cnt_lo <= rx_data;
            if (state == HDR1 && xfer) begin
                count    <= hdr_count[AW:0];
                byte_idx <= '0;
            end
            // First byte ends up in the low lane after three shifts.
            if (state == DATA && xfer) begin
                word_buf <= {rx_data, word_buf[23:8]};
                byte_idx <= byte_idx + 1'b1;
                if (byte_idx == 2'd3) begin
                    mem_w_data <= {rx_data, word_buf};
                    mem_w_addr <= word_cnt[AW-1:0];
                end
            end
            if (state == WRITE) begin
                word_cnt <= word_cnt + 1'b1;
                byte_idx <= '0;
            end
        end
    end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed stimulus with a write scoreboard checked by an independent monitor.
module tb_inst_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready, mem_w_en, core_rst, busy, done, error;
    logic [9:0]  mem_w_addr;
    logic [31:0] mem_w_data;

    int checks = 0;
    int errors = 0;
    logic [41:0] exp_q[$];
    logic [7:0]  img[$];

    inst_loader #(.INST_WIDTH(32), .INST_MEMORY_ADDRESS_WIDTH(10)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr),
        .mem_w_data(mem_w_data), .core_rst(core_rst), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (mem_w_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %h data %h with no write expected", mem_w_addr, mem_w_data);
            end else begin
                logic [41:0] e;
                e = exp_q.pop_front();
                if ({mem_w_addr, mem_w_data} !== e)
                    begin errors++; $display("FAIL write: got addr %h data %h expected addr %h data %h", mem_w_addr, mem_w_data, e[41:32], e[31:0]); end
            end
            checks++;
            if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_ready_in_write: got %b expected 0", rx_ready); end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && n < 100) begin @(negedge clk); n++; end
        if (!rx_ready) begin
            checks++; errors++;
            $display("FAIL rx_ready_timeout: byte %h not accepted within 100 cycles", b);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_image(input int gap);
        foreach (img[i]) begin
            send_byte(img[i]);
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 50) begin @(negedge clk); n++; end
        chk("done_reached", done, 1'b1);
        chk("done_core_rst", core_rst, 1'b0);
        chk("done_busy", busy, 1'b0);
        chk("done_error", error, 1'b0);
    endtask

    initial begin
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("rst_core_rst", core_rst, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_rx_ready", rx_ready, 1'b0);
        chk("rst_mem_w_en", mem_w_en, 1'b0);
        chk("rst_addr", mem_w_addr, 10'h000);
        chk("rst_data", mem_w_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic two-word load, continuous stream
        pulse_start();
        @(negedge clk);
        chk("start_busy", busy, 1'b1);
        chk("start_rx_ready", rx_ready, 1'b1);
        @(posedge clk); #1;
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        exp_q.push_back({10'd0, 32'h00100513});
        exp_q.push_back({10'd1, 32'h00200593});
        send_image(0);
        @(negedge clk);
        chk("last_write_strobe", mem_w_en, 1'b1);
        chk("last_write_done", done, 1'b0);
        chk("last_write_core_rst", core_rst, 1'b1);
        @(negedge clk);
        chk("basic_done", done, 1'b1);
        chk("basic_core_rst", core_rst, 1'b0);
        chk("basic_busy", busy, 1'b0);

        // Reload from DONE with a gappy stream
        @(posedge clk); #1;
        pulse_start();
        @(negedge clk);
        chk("reload_core_rst", core_rst, 1'b1);
        chk("reload_done", done, 1'b0);
        chk("reload_busy", busy, 1'b1);
        @(posedge clk); #1;
        exp_q.push_back({10'd0, 32'h00100513});
        exp_q.push_back({10'd1, 32'h00200593});
        send_image(1);
        wait_done();

        // Zero count header
        @(posedge clk); #1;
        pulse_start();
        img = '{8'h00, 8'h00};
        send_image(0);
        @(negedge clk);
        chk("zero_error", error, 1'b1);
        chk("zero_core_rst", core_rst, 1'b1);
        chk("zero_busy", busy, 1'b0);
        chk("zero_rx_ready", rx_ready, 1'b0);

        // Oversized count 0x401
        @(posedge clk); #1;
        pulse_start();
        @(negedge clk);
        chk("restart_from_error", error, 1'b0);
        @(posedge clk); #1;
        img = '{8'h01, 8'h04};
        send_image(0);
        @(negedge clk);
        chk("big_error", error, 1'b1);
        chk("big_core_rst", core_rst, 1'b1);

        // Abort mid-word with rst
        @(posedge clk); #1;
        pulse_start();
        img = '{8'h01, 8'h00, 8'hAA, 8'hBB};
        send_image(0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_rx_ready", rx_ready, 1'b0);
        chk("abort_core_rst", core_rst, 1'b1);
        chk("abort_error", error, 1'b0);

        // Restart with start and a stray byte together in IDLE; start mid-load is ignored
        @(posedge clk); #1;
        start = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
        @(posedge clk); #1;
        start = 1'b0; rx_valid = 1'b0;
        exp_q.push_back({10'd0, 32'hDEADBEEF});
        img = '{8'h01, 8'h00, 8'hEF, 8'hBE};
        send_image(0);
        pulse_start();
        img = '{8'hAD, 8'hDE};
        send_image(0);
        wait_done();

        // Full-depth image of 1024 words
        @(posedge clk); #1;
        pulse_start();
        img = '{8'h00, 8'h04};
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] w;
            w = 32'hC0DE0000 | 32'(i);
            img.push_back(w[7:0]); img.push_back(w[15:8]);
            img.push_back(w[23:16]); img.push_back(w[31:24]);
            exp_q.push_back({10'(i), w});
        end
        send_image(0);
        wait_done();
        chk("full_last_addr", mem_w_addr, 10'h3FF);
        chk("full_last_data", mem_w_data, 32'hC0DE03FF);

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
